// File: rtl/iter_normalizer.sv
// Multi-cycle normalizer: shifts an operand until its MSB (left) or LSB (right) is set,
// reporting the applied shift amount; valid/ready handshakes on both sides.
module iter_normalizer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_dir,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(WIDTH):0]     out_count,
  output logic                       out_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CW-1:0]    count_q, count_d;
  logic             zero_q,  zero_d;
  logic             dir_q,   dir_d;

  logic target_set;
  logic step_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      zero_q  <= zero_d;
      dir_q   <= dir_d;
    end
  end

  assign target_set = dir_q ? data_q[0] : data_q[WIDTH-1];
  assign step_clear = dir_q ? (data_q[STEP-1:0] == '0) : (data_q[WIDTH-1 -: STEP] == '0);

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    count_d   = count_q;
    zero_d    = zero_q;
    dir_d     = dir_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dir_d   = in_dir;
          count_d = '0;
          if (in_data == '0) begin
            data_d  = '0;
            count_d = CW'(WIDTH);
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            data_d  = in_data;
            zero_d  = 1'b0;
            state_d = SHIFT;
          end
        end
      end

      // Coarse STEP-wide shift while the target end is clear, then single-bit refinement.
      SHIFT: begin
        if (target_set) begin
          state_d = DONE;
        end else if (step_clear) begin
          data_d  = dir_q ? (data_q >> STEP) : (data_q << STEP);
          count_d = count_q + CW'(STEP);
        end else begin
          data_d  = dir_q ? (data_q >> 1) : (data_q << 1);
          count_d = count_q + CW'(1);
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign out_data  = data_q;
  assign out_count = count_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_iter_normalizer.sv
// Scoreboard bench for iter_normalizer: directed operands push expected results,
// an independent monitor pops and compares whenever a result is consumed.
module tb_iter_normalizer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_dir;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_count;
  logic        out_zero;

  iter_normalizer #(.WIDTH(32), .STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_zero  (out_zero)
  );

  typedef struct {
    logic [31:0] d;
    logic [5:0]  c;
    logic        z;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int unsigned cyc     = 0;
  int unsigned acc_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: latency measured to the first cycle out_valid is seen; compare on consumption.
  bit          seen = 1'b0;
  int unsigned first_cyc = 0;
  always @(negedge clk) begin
    if (!rst_n || !out_valid) begin
      seen = 1'b0;
    end else begin
      if (!seen) begin
        seen      = 1'b1;
        first_cyc = cyc;
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data",  64'(out_data),  64'(e.d));
          chk("out_count", 64'(out_count), 64'(e.c));
          chk("out_zero",  64'(out_zero),  64'(e.z));
          chk("latency",   64'(first_cyc - acc_cyc), 64'(e.lat));
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic dir,
                      input logic [31:0] ed, input logic [5:0] ec, input logic ez,
                      input int unsigned lat, input bit push);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    if (push) begin
      e.d = ed; e.c = ec; e.z = ez; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_data  = 32'hA5A5_5A5A;
    in_dir   = ~dir;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && in_ready && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic run(input logic [31:0] d, input logic dir,
                     input logic [31:0] ed, input logic [5:0] ec, input logic ez,
                     input int unsigned lat);
    send(d, dir, ed, ec, ez, lat, 1'b1);
    wait_idle();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dir    = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_out_zero",  64'(out_zero),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(32'h0000_0001, 1'b0, 32'h8000_0000, 6'd31, 1'b0, 11);
    run(32'h8000_0000, 1'b0, 32'h8000_0000, 6'd0,  1'b0, 1);
    run(32'h0000_0000, 1'b0, 32'h0000_0000, 6'd32, 1'b1, 0);
    run(32'h0000_0000, 1'b1, 32'h0000_0000, 6'd32, 1'b1, 0);
    run(32'h0000_0100, 1'b1, 32'h0000_0001, 6'd8,  1'b0, 3);
    run(32'h0000_0001, 1'b1, 32'h0000_0001, 6'd0,  1'b0, 1);
    run(32'h8000_0000, 1'b1, 32'h0000_0001, 6'd31, 1'b0, 11);
    run(32'h0000_0F00, 1'b0, 32'hF000_0000, 6'd20, 1'b0, 6);
    run(32'h0000_0060, 1'b1, 32'h0000_0003, 6'd5,  1'b0, 3);
    run(32'h1234_5678, 1'b0, 32'h91A2_B3C0, 6'd3,  1'b0, 4);

    // Back-pressure: result must hold in DONE and a stray in_valid must be ignored.
    out_ready = 1'b0;
    send(32'h0000_0400, 1'b1, 32'h0000_0001, 6'd10, 1'b0, 5, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("hold_valid_timeout", 64'd1, 64'd0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready",  64'(in_ready),  64'd0);
      chk("hold_out_data",  64'(out_data),  64'h1);
      chk("hold_out_count", 64'(out_count), 64'd10);
      chk("hold_out_zero",  64'(out_zero),  64'd0);
      in_valid = (i == 2);
      in_data  = 32'h0000_0000;
      in_dir   = 1'b0;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    repeat (3) begin
      @(negedge clk);
      chk("no_stray_accept", 64'({in_ready, out_valid}), 64'b10);
    end

    // Reset mid-SHIFT discards the operand.
    send(32'h0001_0000, 1'b0, 32'h0, 6'd0, 1'b0, 0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("midshift_busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    chk("arst_out_data",  64'(out_data),  64'd0);
    chk("arst_out_count", 64'(out_count), 64'd0);
    chk("arst_out_zero",  64'(out_zero),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(32'h00F0_0000, 1'b0, 32'hF000_0000, 6'd8, 1'b0, 3);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
